instr_fetch_queue: RTL and testbench

//  Instruction fetch front-end sitting directly upstream of the datapath decode/execute logic.

---
 rtl/instr_fetch_queue.sv | 139 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one word read at a
// time to instruction memory, and buffers returned words with their PCs in a
// small FIFO that feeds decode. Redirects flush the FIFO, and any request
// still in flight is drained and discarded.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {FETCH, DROP} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_pend_addr;
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [31:0]    r_mem_inst [DEPTH];
    logic [31:0]    r_mem_pc   [DEPTH];

    logic           w_req;
    logic [31:0]    w_addr;
    logic           w_fire;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;
    logic [31:0]    w_redir_pc;

    // Request and handshake decode, all combinational from state; reset
    // masks the request so nothing is issued while rst is held.
    always_comb begin
        w_req      = !rst && ((r_state == FETCH && r_count != CNT_FULL) || r_state == DROP);
        w_addr     = (r_state == DROP) ? r_pend_addr : r_fetch_pc;
        w_fire     = w_req && imem_ack;
        w_push     = (r_state == FETCH) && w_fire && !redirect;
        w_valid    = !rst && (r_count != '0);
        w_pop      = w_valid && inst_ready;
        w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
    end

    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst_valid = w_valid;
    assign inst       = w_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    // Next-state logic: a redirect with a request still unanswered must wait
    // out that request in DROP; an answered one simply loses its data.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            if (w_req && !imem_ack) begin
                w_state_nxt = DROP;
            end else begin
                w_state_nxt = FETCH;
            end
        end else if (r_state == DROP && w_fire) begin
            w_state_nxt = FETCH;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC and the address of a request being drained after a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_pend_addr <= 32'h0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= w_redir_pc;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (redirect && w_req && !imem_ack) begin
                r_pend_addr <= w_addr;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect flushes and discards any
    // same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: in-order fetch, full FIFO
// back-pressure, redirect during a slow request, redirect colliding with
// ack/pop, PC wrap-around and reset while draining.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        ack_auto;
    logic        ack_man;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        inst_valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_ack    = ack_auto ? imem_req : ack_man;
    assign imem_rdata  = word_at(imem_addr);
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = word_at(imem_addr2);

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .inst_ready(1'b1)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic auto_ack, input logic ready);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack_auto    = auto_ack;
        ack_man     = 1'b0;
        inst_ready  = ready;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        ack_auto = 1'b1; ack_man = 1'b0; inst_ready = 1'b1;
        next_cycle();
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL reset_head got inst %h pc %h want 0 0", inst, inst_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'd0; exp_addr[1] = 32'd4; exp_addr[2] = 32'd8; exp_addr[3] = 32'd12;
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr[i]) begin
                errors++; $display("FAIL stream_addr%0d got req %0b addr %h want 1 %h", i, imem_req, imem_addr, exp_addr[i]);
            end
            if (i == 0) begin
                checks++;
                if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %0b want 0", inst_valid); end
            end else begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_addr[i-1] || inst !== word_at(exp_addr[i-1])) begin
                    errors++; $display("FAIL stream_head%0d got v %0b pc %h inst %h want 1 %h %h", i, inst_valid, inst_pc, inst, exp_addr[i-1], word_at(exp_addr[i-1]));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_full();
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) next_cycle();
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %0b want 0", imem_req); end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== word_at(32'd0)) begin
            errors++; $display("FAIL full_head got v %0b pc %h want 1 00000000", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        next_cycle();
        inst_ready = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
            errors++; $display("FAIL full_resume got req %0b addr %h want 1 00000010", imem_req, imem_addr);
        end
        checks++;
        if (inst_pc !== 32'd4) begin errors++; $display("FAIL full_after_pop got pc %h want 00000004", inst_pc); end
    endtask

    task automatic test_redirect_pending();
        apply_reset(1'b1, 1'b0);
        next_cycle();
        next_cycle();
        ack_auto = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL pend_req got req %0b addr %h want 1 00000008", imem_req, imem_addr);
        end
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h43;
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL drop_hold got req %0b addr %h want 1 00000008", imem_req, imem_addr);
        end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_flush got valid %0b want 0", inst_valid); end
        next_cycle();
        ack_man = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 32'h8) begin errors++; $display("FAIL drop_ack_addr got %h want 00000008", imem_addr); end
        next_cycle();
        ack_man = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL drop_done got req %0b addr %h v %0b want 1 00000040 0", imem_req, imem_addr, inst_valid);
        end
        ack_man = 1'b1;
        next_cycle();
        ack_man = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== word_at(32'h40)) begin
            errors++; $display("FAIL redir_first got v %0b pc %h inst %h want 1 00000040 %h", inst_valid, inst_pc, inst, word_at(32'h40));
        end
        checks++;
        if (imem_addr !== 32'h44) begin errors++; $display("FAIL redir_next_addr got %h want 00000044", imem_addr); end
    endtask

    task automatic test_redirect_collide();
        apply_reset(1'b1, 1'b0);
        next_cycle();
        next_cycle();
        checks++;
        if (inst_valid !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL collide_setup got v %0b addr %h want 1 00000008", inst_valid, imem_addr);
        end
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        next_cycle();
        inst_ready = 1'b0; redirect = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL collide_flush got v %0b req %0b addr %h want 0 1 00000100", inst_valid, imem_req, imem_addr);
        end
        next_cycle();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
            errors++; $display("FAIL collide_first got v %0b pc %h want 1 00000100", inst_valid, inst_pc);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        rst2 = 1'b0;
        #1;
        checks++;
        if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_first_addr got %h want fffffff8", imem_addr2); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (inst_valid2 !== 1'b1 || inst_pc2 !== exp_pc[i] || inst2 !== word_at(exp_pc[i])) begin
                errors++; $display("FAIL wrap_pc%0d got v %0b pc %h want 1 %h", i, inst_valid2, inst_pc2, exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_in_drop();
        apply_reset(1'b1, 1'b0);
        next_cycle();
        ack_auto = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL rdrop_setup got req %0b addr %h want 1 00000004", imem_req, imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL rdrop_async got req %0b v %0b inst %h pc %h want 0 0 0 0", imem_req, inst_valid, inst, inst_pc);
        end
        next_cycle();
        rst = 1'b0;
        ack_man = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rdrop_release got req %0b addr %h want 1 00000000", imem_req, imem_addr);
        end
        next_cycle();
        ack_man = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL rdrop_fetch_state got v %0b pc %h want 1 00000000", inst_valid, inst_pc);
        end
    endtask

    initial begin
        rst2 = 1'b1;
        test_reset();
        test_stream();
        test_full();
        test_redirect_pending();
        test_redirect_collide();
        test_pc_wrap();
        test_reset_in_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
